// File: rtl/kbd_pkg.sv
// Shared register map, bit positions and event payload for the PS/2 keyboard controller.
package kbd_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int unsigned ST_NEMPTY    = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_PERR      = 3;
  localparam int unsigned ST_IE        = 4;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned CTRL_IE    = 0;
  localparam int unsigned CTRL_FLUSH = 1;
  localparam int unsigned CTRL_CLR   = 2;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect,
// 11-bit frame FSM with odd-parity/stop check and an inactivity timeout.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          fall_c;
  logic          d_c;

  // Third clk stage is the edge register, so an edge is acted on 3 clk after the pin moves.
  assign fall_c = clk_sync_q[2] & ~clk_sync_q[1];
  assign d_c    = dat_sync_q[1];

  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2c};
    dat_sync_d   = {dat_sync_q[0], ps2d};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == S_IDLE || fall_c) ? '0 : tmo_q + TW'(1);
    if (fall_c) begin
      case (state_q)
        S_IDLE: begin
          if (!d_c) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {d_c, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_ok_d = ^{shift_q, d_c};
          state_d  = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (par_ok_q && d_c) byte_valid_d = 1'b1;
          else                 frame_err_d  = 1'b1;
        end
      endcase
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: prefix decoder, event FIFO, STB/ACK register slave
// and maskable level interrupt.
module ps2_kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic        ADDR,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ACK,
  input  logic        PS2C,
  input  logic        PS2D,
  output logic        INT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic BUS_IDLE = 1'b0;
  localparam logic BUS_HOLD = 1'b1;

  logic          rx_valid, rx_err;
  logic [7:0]    rx_byte;
  kbd_event_t    mem_q [FIFO_DEPTH];
  kbd_event_t    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          bus_state_q, bus_state_d;
  logic          ack_q, ack_d, int_q, int_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ie_q, ie_d, ovf_q, ovf_d, perr_q, perr_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic          empty_c, full_c, accept_c, push_req_c, push_c, pop_c, flush_c;
  logic [31:0]   status_c;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:3];

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2c       (PS2C),
    .ps2d       (PS2D),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .frame_err  (rx_err)
  );

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(FIFO_DEPTH));

  always_comb begin
    status_c                        = '0;
    status_c[ST_NEMPTY]             = ~empty_c;
    status_c[ST_FULL]               = full_c;
    status_c[ST_OVF]                = ovf_q;
    status_c[ST_PERR]               = perr_q;
    status_c[ST_IE]                 = ie_q;
    status_c[ST_COUNT_LSB +: 8]     = 8'(count_q);
  end

  always_comb begin
    bus_state_d = bus_state_q;
    ack_d       = 1'b0;
    rdata_d     = '0;
    ie_d        = ie_q;
    ovf_d       = ovf_q;
    perr_d      = perr_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push_req_c  = 1'b0;
    pop_c       = 1'b0;
    flush_c     = 1'b0;

    // HOLD blocks re-acceptance until STB has been seen low once.
    accept_c = (bus_state_q == BUS_IDLE) && STB;
    if (bus_state_q == BUS_IDLE) begin
      if (STB) bus_state_d = BUS_HOLD;
    end else if (!STB) begin
      bus_state_d = BUS_IDLE;
    end

    if (accept_c) begin
      ack_d = 1'b1;
      if (!WE && ADDR == ADDR_DATA) begin
        pop_c = ~empty_c;
        if (!empty_c) rdata_d = {21'b0, 1'b1, mem_q[rd_ptr_q]};
      end else if (!WE) begin
        rdata_d = status_c;
      end else if (ADDR == ADDR_STAT) begin
        ie_d    = wdata[CTRL_IE];
        flush_c = wdata[CTRL_FLUSH];
        if (wdata[CTRL_CLR]) begin
          ovf_d  = 1'b0;
          perr_d = 1'b0;
        end
      end
    end

    if (rx_valid) begin
      if (rx_byte == PREFIX_EXT)      ext_pend_d = 1'b1;
      else if (rx_byte == PREFIX_BRK) brk_pend_d = 1'b1;
      else begin
        push_req_c = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
    if (rx_err) begin
      perr_d     = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    push_c = push_req_c && (!full_c || pop_c);
    if (push_req_c && !push_c) ovf_d = 1'b1;
    if (push_c) begin
      mem_d[wr_ptr_q] = '{ext: ext_pend_q, brk: brk_pend_q, code: rx_byte};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_c) - CW'(pop_c);

    if (flush_c) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    int_d = ie_q & ~empty_c;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_state_q <= BUS_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      int_q       <= 1'b0;
      ie_q        <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      bus_state_q <= bus_state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      int_q       <= int_d;
      ie_q        <= ie_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign ACK   = ack_q;
  assign rdata = rdata_q;
  assign INT   = int_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed scenarios plus random frames/bus traffic
// checked against a queue-based model of the keyboard event stream.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset, STB, WE, ADDR, ACK, PS2C, PS2D, INT;
  logic [31:0] wdata, rdata;

  int vecs;
  int errs;

  logic [9:0] mq[$];
  bit m_ext, m_brk, m_ovf, m_perr, m_ie;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
    .clk   (clk),
    .reset (reset),
    .STB   (STB),
    .WE    (WE),
    .ADDR  (ADDR),
    .wdata (wdata),
    .rdata (rdata),
    .ACK   (ACK),
    .PS2C  (PS2C),
    .PS2D  (PS2D),
    .INT   (INT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic full;
    full = (mq.size() == DEPTH);
    return {16'b0, 8'(mq.size()), 3'b0, m_ie, m_perr, m_ovf, full, mq.size() != 0};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_ie = 0;
  endtask

  task automatic model_rx(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_perr = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input bit b);
    @(negedge clk); PS2D = b;
    repeat (5) @(negedge clk);
    PS2C = 1'b0;
    repeat (10) @(negedge clk);
    PS2C = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    bit p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    repeat (6) @(negedge clk);
    model_rx(b, !bad_par);
  endtask

  task automatic bus_txn(input bit we, input bit addr, input logic [31:0] wd, output logic [31:0] rd);
    bit ok;
    @(negedge clk);
    STB = 1'b1; WE = we; ADDR = addr; wdata = wd;
    ok = 0; rd = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (ACK) begin ok = 1; rd = rdata; end
    end
    STB = 1'b0;
    if (!ok) check("ack_timeout", 32'(ACK), 32'd1);
    @(negedge clk);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] rd, exp;
    bus_txn(1'b0, 1'b0, 32'h0, rd);
    exp = (mq.size() != 0) ? {21'b0, 1'b1, mq.pop_front()} : 32'h0;
    check(tag, rd, exp);
  endtask

  task automatic read_stat(input string tag);
    logic [31:0] rd;
    bus_txn(1'b0, 1'b1, 32'h0, rd);
    check(tag, rd, exp_status());
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    logic [31:0] rd;
    bus_txn(1'b1, 1'b1, v, rd);
    m_ie = v[0];
    if (v[2]) begin m_ovf = 0; m_perr = 0; end
    if (v[1]) begin mq.delete(); m_ext = 0; m_brk = 0; end
  endtask

  task automatic do_reset();
    reset = 1'b1; STB = 1'b0; WE = 1'b0; ADDR = 1'b0; wdata = '0;
    PS2C = 1'b1; PS2D = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, cap, exp;
    logic [7:0]  b;
    int          acks, r;
    vecs = 0; errs = 0;

    do_reset();
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_int", 32'(INT), 32'd0);
    read_stat("rst_status");

    // Make code
    send_frame(8'h1C, 1'b0);
    read_stat("make_stat1");
    read_data("make_data");
    read_stat("make_stat0");

    // Extended break
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    read_stat("extbrk_stat");
    bus_txn(1'b0, 1'b0, 32'h0, rd);
    check("extbrk_data", rd, 32'h0000_0774);
    void'(mq.pop_front());

    // Parity error, then clear
    send_frame(8'h1C, 1'b1);
    read_stat("perr_stat");
    write_ctrl(32'h4);
    read_stat("perr_clr");

    // Overflow with depth 4
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0);
    bus_txn(1'b0, 1'b1, 32'h0, rd);
    check("ovf_stat", rd, 32'h0000_0407);
    for (int i = 1; i <= 5; i++) read_data("ovf_data");
    write_ctrl(32'h4);

    // Timeout: partial frame, long idle, then a full frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (150) @(negedge clk);
    send_frame(8'h2A, 1'b0);
    read_stat("tmo_stat");
    read_data("tmo_data");
    read_data("tmo_empty");

    // A start bit of 1 is ignored
    ps2_bit(1'b1);
    send_frame(8'h15, 1'b0);
    read_data("start1_data");

    // INT gating and held STB
    send_frame(8'h3B, 1'b0);
    check("int_masked", 32'(INT), 32'd0);
    write_ctrl(32'h1);
    check("int_on", 32'(INT), 32'd1);
    @(negedge clk);
    STB = 1'b1; WE = 1'b0; ADDR = 1'b0;
    acks = 0; cap = '0;
    repeat (5) begin
      @(negedge clk);
      if (ACK) begin acks++; cap = rdata; end
    end
    STB = 1'b0;
    repeat (2) @(negedge clk);
    exp = {21'b0, 1'b1, mq.pop_front()};
    check("held_acks", 32'(acks), 32'd1);
    check("held_rdata", cap, exp);
    check("held_int", 32'(INT), 32'd0);
    read_stat("held_stat");

    // Randomised traffic against the model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          r = $urandom_range(0, 9);
          b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
          send_frame(b, $urandom_range(0, 9) == 0);
        end
        2: read_data("rnd_data");
        3: read_stat("rnd_stat");
        4: write_ctrl({29'b0, 3'($urandom_range(0, 7))});
        default: check("rnd_int", 32'(INT), 32'(m_ie && mq.size() != 0));
      endcase
    end
    check("rnd_int_end", 32'(INT), 32'(m_ie && mq.size() != 0));
    while (mq.size() != 0) read_data("rnd_drain");
    read_stat("rnd_final");

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    do_reset();
    read_stat("midrst_stat");
    send_frame(8'h33, 1'b0);
    read_data("midrst_data");
    read_stat("midrst_stat2");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
